// File: rtl/mem_arbiter.sv
// Two-master (fetch, data) to one-slave memory arbiter with a registered grant FSM,
// data-run fairness limit and an ack watchdog that aborts stalled transactions with err.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  // Fetch port
  input  logic        i_stb,
  input  logic [29:0] i_adr,
  output logic [31:0] i_dat,
  output logic        i_ack,
  output logic        i_err,
  // Data port
  input  logic        d_stb,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [29:0] d_adr,
  input  logic [31:0] d_wdat,
  output logic [31:0] d_rdat,
  output logic        d_ack,
  output logic        d_err,
  // Memory port
  output logic        m_stb,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [29:0] m_adr,
  output logic [31:0] m_wdat,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack
);

  localparam logic [3:0] RunMax  = 4'(MAX_DATA_RUN);
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e     state_q, state_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic gnt_i, gnt_d, stb_gnt, tmo_hit;

  always_comb begin
    gnt_i   = (state_q == StGntI);
    gnt_d   = (state_q == StGntD);
    stb_gnt = (gnt_i & i_stb) | (gnt_d & d_stb);
    // Ack in the expiry cycle takes priority over the timeout.
    tmo_hit = (gnt_i | gnt_d) & (tmo_cnt_q == TmoLast) & ~m_ack;
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    unique case (state_q)
      StIdle: begin
        tmo_cnt_d = 8'd0;
        if (d_stb && !(i_stb && run_cnt_q == RunMax)) begin
          state_d = StGntD;
          if (i_stb && run_cnt_q != RunMax) run_cnt_d = run_cnt_q + 4'd1;
        end else if (i_stb) begin
          state_d   = StGntI;
          run_cnt_d = 4'd0;
        end
      end
      StGntI, StGntD: begin
        // Drop of the granted stb is a silent abort: no ack, no err.
        if (m_ack || tmo_hit || !stb_gnt) begin
          state_d   = StIdle;
          tmo_cnt_d = 8'd0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      run_cnt_q <= 4'd0;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    m_stb  = stb_gnt & ~rst;
    m_we   = 1'b0;
    m_sel  = 4'h0;
    m_adr  = 30'h0;
    m_wdat = 32'h0;
    if (gnt_d) begin
      m_we   = d_we;
      m_sel  = d_sel;
      m_adr  = d_adr;
      m_wdat = d_wdat;
    end else if (gnt_i) begin
      m_sel  = 4'hf;
      m_adr  = i_adr;
    end
    i_ack  = gnt_i & m_ack & ~rst;
    d_ack  = gnt_d & m_ack & ~rst;
    i_err  = gnt_i & i_stb & tmo_hit & ~rst;
    d_err  = gnt_d & d_stb & tmo_hit & ~rst;
    i_dat  = m_dat_i;
    d_rdat = m_dat_i;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, write, contention, watchdog, abort, reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stb, d_stb, d_we, m_ack;
  logic [29:0] i_adr, d_adr, m_adr;
  logic [31:0] i_dat, d_rdat, d_wdat, m_wdat, m_dat_i;
  logic [3:0]  d_sel, m_sel;
  logic        i_ack, i_err, d_ack, d_err, m_stb, m_we;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_stb(i_stb), .i_adr(i_adr), .i_dat(i_dat), .i_ack(i_ack), .i_err(i_err),
    .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr), .d_wdat(d_wdat),
    .d_rdat(d_rdat), .d_ack(d_ack), .d_err(d_err),
    .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_wdat(m_wdat),
    .m_dat_i(m_dat_i), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_stb = 0; i_adr = '0; d_stb = 0; d_we = 0; d_sel = '0; d_adr = '0; d_wdat = '0;
    m_ack = 0; m_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    cyc();
    cyc();
    i_stb = 1; d_stb = 1; m_ack = 1;
    #1;
    checks++;
    if ({m_stb, i_ack, d_ack, i_err, d_err} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b, expected 00000",
                         {m_stb, i_ack, d_ack, i_err, d_err});
    end
    cyc();
    checks++;
    if (m_stb !== 1'b0) begin
      errors++; $display("FAIL reset_held_idle: m_stb got %b, expected 0", m_stb);
    end
    clear_inputs();
    rst = 0;
    cyc();
    checks++;
    if (m_stb !== 1'b0 || m_sel !== 4'h0 || m_adr !== 30'h0 || m_we !== 1'b0) begin
      errors++; $display("FAIL reset_idle_mux: stb=%b sel=%h adr=%h we=%b, expected 0/0/0/0",
                         m_stb, m_sel, m_adr, m_we);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_stb = 1; i_adr = 30'h10;
    #1;
    checks++;
    if (m_stb !== 1'b0) begin
      errors++; $display("FAIL fetch_c0_stb: got %b, expected 0", m_stb);
    end
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b1 || m_adr !== 30'h10 || m_sel !== 4'hf || m_we !== 1'b0 || i_ack !== 1'b0)
    begin
      errors++; $display("FAIL fetch_c1_req: stb=%b adr=%h sel=%h we=%b ack=%b, expected 1/10/f/0/0",
                         m_stb, m_adr, m_sel, m_we, i_ack);
    end
    cyc();
    m_ack = 1; m_dat_i = 32'hE3A00001;
    #1;
    checks++;
    if (i_ack !== 1'b1 || i_dat !== 32'hE3A00001 || d_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_c2_ack: i_ack=%b i_dat=%h d_ack=%b, expected 1/e3a00001/0",
                         i_ack, i_dat, d_ack);
    end
    cyc();
    m_ack = 0; i_stb = 0;
    #1;
    checks++;
    if (m_stb !== 1'b0 || i_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_c3_idle: stb=%b ack=%b, expected 0/0", m_stb, i_ack);
    end
  endtask

  task automatic test_data_write();
    int nack = 0;
    int niack = 0;
    do_reset();
    d_stb = 1; d_we = 1; d_sel = 4'h3; d_adr = 30'h20; d_wdat = 32'hCAFEF00D;
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b1 || m_we !== 1'b1 || m_sel !== 4'h3 || m_adr !== 30'h20 ||
        m_wdat !== 32'hCAFEF00D) begin
      errors++; $display("FAIL write_mux: stb=%b we=%b sel=%h adr=%h wdat=%h, expected 1/1/3/20/cafef00d",
                         m_stb, m_we, m_sel, m_adr, m_wdat);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 1) m_ack = 1;
      if (k == 2) begin m_ack = 0; d_stb = 0; end
      #1;
      if (d_ack) nack++;
      if (i_ack) niack++;
      cyc();
    end
    checks++;
    if (nack !== 1) begin
      errors++; $display("FAIL write_ack_count: got %0d, expected 1", nack);
    end
    checks++;
    if (niack !== 0) begin
      errors++; $display("FAIL write_no_iack: got %0d, expected 0", niack);
    end
  endtask

  task automatic test_contention();
    logic [9:0] seq = '0;
    logic [9:0] exp_seq = 10'b1000010000;
    int ng = 0;
    do_reset();
    i_stb = 1; i_adr = 30'h100; d_stb = 1; d_adr = 30'h200;
    for (int k = 0; k < 24; k++) begin
      cyc();
      m_ack = m_stb;
      #1;
      if (ng < 10 && d_ack) begin seq[ng] = 1'b0; ng++; end
      else if (ng < 10 && i_ack) begin seq[ng] = 1'b1; ng++; end
    end
    m_ack = 0; i_stb = 0; d_stb = 0;
    checks++;
    if (ng !== 10) begin
      errors++; $display("FAIL contention_grants: got %0d, expected 10", ng);
    end
    for (int g = 0; g < 10; g++) begin
      checks++;
      if (seq[g] !== exp_seq[g]) begin
        errors++; $display("FAIL contention_seq[%0d]: got %s, expected %s", g,
                           seq[g] ? "I" : "D", exp_seq[g] ? "I" : "D");
      end
    end
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    int err_at = -1;
    int nerr = 0;
    int nack = 0;
    do_reset();
    d_stb = 1; d_adr = 30'h55;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      #1;
      if (d_err) begin nerr++; if (err_at < 0) err_at = k; end
      if (d_ack) nack++;
    end
    cyc();
    d_stb = 0;
    #1;
    checks++;
    if (m_stb !== 1'b0) begin
      errors++; $display("FAIL timeout_stb_drop: got %b, expected 0", m_stb);
    end
    for (int k = 0; k < 3; k++) begin
      if (d_err) nerr++;
      if (d_ack) nack++;
      cyc();
    end
    checks++;
    if (err_at !== 64) begin
      errors++; $display("FAIL timeout_cycle: err at grant cycle %0d, expected 64", err_at);
    end
    checks++;
    if (nerr !== 1 || nack !== 0) begin
      errors++; $display("FAIL timeout_counts: err=%0d ack=%0d, expected 1/0", nerr, nack);
    end
    i_stb = 1; i_adr = 30'h7;
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b1 || m_adr !== 30'h7) begin
      errors++; $display("FAIL timeout_next_fetch: stb=%b adr=%h, expected 1/7", m_stb, m_adr);
    end
    m_ack = 1; m_dat_i = 32'h12345678;
    #1;
    checks++;
    if (i_ack !== 1'b1 || i_err !== 1'b0 || i_dat !== 32'h12345678) begin
      errors++; $display("FAIL timeout_next_ack: ack=%b err=%b dat=%h, expected 1/0/12345678",
                         i_ack, i_err, i_dat);
    end
    cyc();
    m_ack = 0; i_stb = 0;
  endtask

  task automatic test_collision_abort();
    do_reset();
    d_stb = 1; d_adr = 30'h66;
    for (int k = 1; k <= 63; k++) cyc();
    cyc();
    m_ack = 1;
    #1;
    checks++;
    if (d_ack !== 1'b1 || d_err !== 1'b0) begin
      errors++; $display("FAIL collision: d_ack=%b d_err=%b, expected 1/0", d_ack, d_err);
    end
    cyc();
    m_ack = 0; d_stb = 0;
    #1;
    checks++;
    if (d_err !== 1'b0 || d_ack !== 1'b0) begin
      errors++; $display("FAIL collision_after: d_ack=%b d_err=%b, expected 0/0", d_ack, d_err);
    end
    i_stb = 1; i_adr = 30'h9;
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b1) begin
      errors++; $display("FAIL abort_grant: m_stb got %b, expected 1", m_stb);
    end
    cyc();
    i_stb = 0;
    #1;
    checks++;
    if ({m_stb, i_ack, i_err} !== 3'b000) begin
      errors++; $display("FAIL abort_drop: stb/ack/err got %b, expected 000", {m_stb, i_ack, i_err});
    end
    d_stb = 1; d_we = 1; d_sel = 4'h1; d_adr = 30'h3;
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b0) begin
      errors++; $display("FAIL abort_idle: m_stb got %b, expected 0", m_stb);
    end
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b1 || m_we !== 1'b1 || m_adr !== 30'h3) begin
      errors++; $display("FAIL abort_regrant: stb=%b we=%b adr=%h, expected 1/1/3", m_stb, m_we, m_adr);
    end
    m_ack = 1;
    #1;
    checks++;
    if (d_ack !== 1'b1) begin
      errors++; $display("FAIL abort_regrant_ack: got %b, expected 1", d_ack);
    end
    cyc();
    m_ack = 0; d_stb = 0; d_we = 0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    i_stb = 1; d_stb = 1; d_we = 1; d_adr = 30'h44;
    cyc();
    #1;
    checks++;
    if (m_stb !== 1'b1 || m_we !== 1'b1 || dut.run_cnt_q !== 4'd1) begin
      errors++; $display("FAIL midop_grant: stb=%b we=%b run=%0d, expected 1/1/1",
                         m_stb, m_we, dut.run_cnt_q);
    end
    cyc();
    rst = 1;
    #1;
    checks++;
    if (m_stb !== 1'b0) begin
      errors++; $display("FAIL midop_rst_stb: got %b, expected 0", m_stb);
    end
    cyc();
    rst = 0; i_stb = 0; d_stb = 0; m_ack = 1;
    #1;
    checks++;
    if ({m_stb, d_ack, i_ack, d_err, i_err} !== 5'b0 || dut.run_cnt_q !== 4'd0) begin
      errors++; $display("FAIL midop_late_ack: stb/dack/iack/derr/ierr=%b run=%0d, expected 00000/0",
                         {m_stb, d_ack, i_ack, d_err, i_err}, dut.run_cnt_q);
    end
    cyc();
    m_ack = 0;
    #1;
    checks++;
    if (m_stb !== 1'b0) begin
      errors++; $display("FAIL midop_idle: m_stb got %b, expected 0", m_stb);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_contention();
    test_timeout();
    test_collision_abort();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
